// File: rtl/text_writer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// text_writer
//   Byte-stream console writer for the VGA text RAM (port A side).
//   Printable bytes are written as {attr, char} at the cursor position,
//   CR/LF/BS move the cursor, ESC loads the next byte as the attribute,
//   FF sweeps the whole RAM with spaces.
//   Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module text_writer #(
    parameter int unsigned COLS         = 30,
    parameter int unsigned ROWS         = 17,
    parameter int unsigned ROW_SHIFT    = 5,
    parameter int unsigned ADDR_W       = 10,
    parameter logic [7:0]  DEFAULT_ATTR = 8'h07
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ram_cea,
    output logic [ADDR_W-1:0] ram_ada,
    output logic [15:0]       ram_din,
    output logic [4:0]        cur_row,
    output logic [4:0]        cur_col,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ESC   = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    // One extra counter bit so the sweep length may equal the full RAM size.
    localparam int unsigned CNT_W       = ADDR_W + 1;
    localparam int unsigned SWEEP_WORDS = ROWS << ROW_SHIFT;
    localparam logic [CNT_W-1:0] SWEEP_END = CNT_W'(SWEEP_WORDS);
    localparam logic [4:0] LAST_COL = 5'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_ESC   = 8'h1B;
    localparam logic [7:0] CH_SPACE = 8'h20;

    state_t            state_q, state_d;
    logic [4:0]        row_q, row_d;
    logic [4:0]        col_q, col_d;
    logic [7:0]        attr_q, attr_d;
    logic              cea_q, cea_d;
    logic [ADDR_W-1:0] ada_q, ada_d;
    logic [15:0]       din_q, din_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              accept;
    logic [4:0]        row_next;
    logic [ADDR_W-1:0] cursor_addr;

    // Ready depends only on state (and reset), never on in_valid.
    assign in_ready = resetn & (state_q != S_CLEAR);
    assign accept   = in_valid & in_ready;
    assign busy     = (state_q == S_CLEAR);

    assign row_next    = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;
    // Row stride is a power of two, so the address is a shift-and-OR.
    assign cursor_addr = (ADDR_W'(row_q) << ROW_SHIFT) | ADDR_W'(col_q);

    assign ram_cea = cea_q;
    assign ram_ada = ada_q;
    assign ram_din = din_q;
    assign cur_row = row_q;
    assign cur_col = col_q;

    // Next-state logic: byte decoding, cursor movement and sweep sequencing.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        attr_d  = attr_q;
        cea_d   = 1'b0;
        ada_d   = ada_q;
        din_d   = din_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (in_data >= CH_SPACE) begin
                        cea_d = 1'b1;
                        ada_d = cursor_addr;
                        din_d = {attr_q, in_data};
                        if (col_q < LAST_COL) begin
                            col_d = col_q + 5'd1;
                        end else begin
                            col_d = 5'd0;
                            row_d = row_next;
                        end
                    end else begin
                        case (in_data)
                            CH_CR: col_d = 5'd0;
                            CH_LF: begin
                                col_d = 5'd0;
                                row_d = row_next;
                            end
                            CH_BS: begin
                                if (col_q != 5'd0) begin
                                    col_d = col_q - 5'd1;
                                end
                            end
                            CH_ESC: state_d = S_ESC;
                            CH_FF: begin
                                state_d = S_CLEAR;
                                cnt_d   = '0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            S_ESC: begin
                if (accept) begin
                    attr_d  = in_data;
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                // The cycle after the final write returns to IDLE, so busy
                // stays high for as long as sweep writes are on the port.
                if (cnt_q == SWEEP_END) begin
                    state_d = S_IDLE;
                    row_d   = 5'd0;
                    col_d   = 5'd0;
                end else begin
                    cea_d = 1'b1;
                    ada_d = cnt_q[ADDR_W-1:0];
                    din_d = {attr_q, CH_SPACE};
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, cursor, attribute and RAM port registers; async reset aborts any sweep.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            row_q   <= 5'd0;
            col_q   <= 5'd0;
            attr_q  <= DEFAULT_ATTR;
            cea_q   <= 1'b0;
            ada_q   <= '0;
            din_q   <= 16'h0000;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            attr_q  <= attr_d;
            cea_q   <= cea_d;
            ada_q   <= ada_d;
            din_q   <= din_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
`default_nettype wire
